// File: rtl/mem_pkg.sv
// Shared definitions for the pipeline memory stage: control-word bit indices,
// access size encodings, multiplier function codes and the bus FSM states.
package mem_pkg;
  localparam int CTRL_REG_WRITE = 2;
  localparam int CTRL_MEM_READ  = 3;
  localparam int CTRL_MEM_WRITE = 4;

  localparam logic [0:1] SZ_BYTE = 2'b00;
  localparam logic [0:1] SZ_HALF = 2'b01;
  localparam logic [0:1] SZ_WORD = 2'b10;

  localparam logic [0:5] ALU_MULT  = 6'h0e;
  localparam logic [0:5] ALU_MULTU = 6'h16;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_WAIT = 1'b1
  } mem_state_e;

  // Any size code with the upper bit set is a word access.
  function automatic logic is_word(input logic [0:1] size);
    return size[0];
  endfunction

  function automatic logic is_half(input logic [0:1] size);
    return !size[0] && size[1];
  endfunction
endpackage

// File: rtl/mem_stage_load_align.sv
// Selects the addressed byte/half lane of a big-endian load word and
// sign- or zero-extends it; word loads pass through unchanged.
module load_align
  import mem_pkg::*;
(
  input  logic [0:31] rdata,
  input  logic [0:1]  lane,
  input  logic [0:1]  size,
  input  logic        sgn,
  output logic [0:31] value
);
  logic [0:7]  b;
  logic [0:15] h;

  always_comb begin
    b     = 8'h00;
    h     = lane[0] ? rdata[16:31] : rdata[0:15];
    value = rdata;
    case (lane)
      2'b00:   b = rdata[0:7];
      2'b01:   b = rdata[8:15];
      2'b10:   b = rdata[16:23];
      default: b = rdata[24:31];
    endcase
    if (is_half(size))
      value = {{16{sgn & h[0]}}, h};
    else if (!is_word(size))
      value = {{24{sgn & b[0]}}, b};
  end
endmodule

// File: rtl/mem_stage.sv
// Pipeline MEMORY stage: data-memory req/ack access with timeout, result
// selection, forwarding taps and the MEM/WB pipeline register.
module mem_stage
  import mem_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [0:8]  ctrl,
  input  logic [0:31] alu_out,
  input  logic [0:31] mult_out,
  input  logic [0:31] write_data,
  input  logic [0:2]  dmem_info,
  input  logic [0:4]  write_reg,
  input  logic [0:5]  alu_ctrl,
  input  logic        fp_reg_write,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic [0:31] dmem_addr,
  output logic [0:3]  dmem_be,
  output logic [0:31] dmem_wdata,
  input  logic        dmem_ack,
  input  logic [0:31] dmem_rdata,
  output logic        mem_stall,
  output logic        bus_error,
  output logic [0:4]  write_reg_mem,
  output logic [0:31] write_val_mem,
  output logic        reg_write_mem,
  output logic [0:8]  ctrl_wb,
  output logic [0:4]  write_reg_wb,
  output logic [0:31] write_val_wb,
  output logic        reg_write_wb,
  output logic        fp_reg_write_wb,
  output mem_state_e  fsm_state
);
  localparam int CNT_W = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TIMEOUT_CYCLES - 1);

  mem_state_e       state;
  logic [CNT_W-1:0] cnt;

  logic        mem_read, mem_write, reg_write, mem_op;
  logic [0:1]  size, lane;
  logic        aligned, timeout, ack_hit, misalign;
  logic [0:31] result, ext_val, ld_val;

  assign mem_read  = ctrl[CTRL_MEM_READ];
  assign mem_write = ctrl[CTRL_MEM_WRITE];
  assign reg_write = ctrl[CTRL_REG_WRITE];
  assign mem_op    = mem_read | mem_write;
  assign size      = dmem_info[1:2];
  assign lane      = alu_out[30:31];

  always_comb begin
    aligned    = 1'b1;
    dmem_be    = 4'b1111;
    dmem_wdata = write_data;
    if (is_word(size)) begin
      aligned = (lane == 2'b00);
    end else if (is_half(size)) begin
      aligned    = !lane[1];
      dmem_be    = lane[0] ? 4'b0011 : 4'b1100;
      dmem_wdata = {2{write_data[16:31]}};
    end else begin
      dmem_be    = 4'b1000 >> lane;
      dmem_wdata = {4{write_data[24:31]}};
    end
  end

  assign result = (alu_ctrl == ALU_MULT || alu_ctrl == ALU_MULTU) ? mult_out : alu_out;

  // Address and data need no holding register: mem_stall freezes EX/MEM.
  assign dmem_addr = {alu_out[0:29], 2'b00};
  assign timeout   = (state == ST_WAIT) && !dmem_ack && (cnt == CNT_MAX);
  // Gated by rst_n so an asserted reset drops the request immediately.
  assign dmem_req  = rst_n && ((state == ST_WAIT) || (mem_op && aligned));
  assign dmem_we   = dmem_req && mem_write;
  assign mem_stall = dmem_req && !dmem_ack && !timeout;
  assign ack_hit   = dmem_req && dmem_ack;
  assign misalign  = (state == ST_IDLE) && mem_op && !aligned;

  load_align u_load_align (
    .rdata (dmem_rdata),
    .lane  (lane),
    .size  (size),
    .sgn   (dmem_info[0]),
    .value (ext_val)
  );

  // Timeouts and misaligned loads both write back zero.
  assign ld_val = ack_hit ? ext_val : 32'h0;

  assign write_reg_mem = write_reg;
  assign write_val_mem = result;
  assign reg_write_mem = reg_write && !mem_read;
  assign fsm_state     = state;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_IDLE;
      cnt       <= '0;
      bus_error <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (dmem_req && !dmem_ack) begin
            state <= ST_WAIT;
            cnt   <= '0;
          end
          if (misalign) bus_error <= 1'b1;
        end
        ST_WAIT: begin
          if (dmem_ack) begin
            state <= ST_IDLE;
          end else if (timeout) begin
            state     <= ST_IDLE;
            bus_error <= 1'b1;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ctrl_wb         <= '0;
      write_reg_wb    <= '0;
      write_val_wb    <= '0;
      reg_write_wb    <= 1'b0;
      fp_reg_write_wb <= 1'b0;
    end else begin
      ctrl_wb         <= mem_stall ? 9'h0 : ctrl;
      write_reg_wb    <= write_reg;
      write_val_wb    <= mem_read ? ld_val : result;
      reg_write_wb    <= !mem_stall && reg_write && !mem_write;
      fp_reg_write_wb <= !mem_stall && fp_reg_write;
    end
  end
endmodule

// File: tb/tb_mem_stage.sv
// Directed bench for mem_stage: a table of single-cycle accesses plus
// hand-written wait-state, misalignment, timeout and mid-access reset sequences.
module tb_mem_stage;
  import mem_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [0:8]  ctrl;
  logic [0:31] alu_out, mult_out, write_data, dmem_rdata;
  logic [0:2]  dmem_info;
  logic [0:4]  write_reg;
  logic [0:5]  alu_ctrl;
  logic        fp_reg_write, dmem_ack;
  logic        dmem_req, dmem_we, mem_stall, bus_error;
  logic [0:31] dmem_addr, dmem_wdata, write_val_mem, write_val_wb;
  logic [0:3]  dmem_be;
  logic [0:4]  write_reg_mem, write_reg_wb;
  logic        reg_write_mem, reg_write_wb, fp_reg_write_wb;
  logic [0:8]  ctrl_wb;
  mem_state_e  fsm_state;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  mem_stage #(.TIMEOUT_CYCLES(16)) dut (
    .clk(clk), .rst_n(rst_n), .ctrl(ctrl), .alu_out(alu_out), .mult_out(mult_out),
    .write_data(write_data), .dmem_info(dmem_info), .write_reg(write_reg),
    .alu_ctrl(alu_ctrl), .fp_reg_write(fp_reg_write), .dmem_req(dmem_req),
    .dmem_we(dmem_we), .dmem_addr(dmem_addr), .dmem_be(dmem_be),
    .dmem_wdata(dmem_wdata), .dmem_ack(dmem_ack), .dmem_rdata(dmem_rdata),
    .mem_stall(mem_stall), .bus_error(bus_error), .write_reg_mem(write_reg_mem),
    .write_val_mem(write_val_mem), .reg_write_mem(reg_write_mem), .ctrl_wb(ctrl_wb),
    .write_reg_wb(write_reg_wb), .write_val_wb(write_val_wb),
    .reg_write_wb(reg_write_wb), .fp_reg_write_wb(fp_reg_write_wb),
    .fsm_state(fsm_state)
  );

  localparam logic [0:8] C_ALU = 9'b001000001;
  localparam logic [0:8] C_LD  = 9'b001100000;
  localparam logic [0:8] C_ST  = 9'b000010000;

  typedef struct {
    logic [0:8]  ctrl;
    logic [0:5]  alu_ctrl;
    logic [0:31] alu_out, mult_out, wdata;
    logic [0:2]  info;
    logic        ack;
    logic [0:31] rdata;
    logic        fp;
    logic        e_req, e_we;
    logic [0:3]  e_be;
    logic [0:31] e_wdata, e_wval_mem;
    logic        e_rw_mem;
    logic [0:31] e_wval_wb;
    logic        e_rw_wb;
  } vec_t;

  vec_t vecs[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic add(input logic [0:8] c, input logic [0:5] ac, input logic [0:31] a,
                     input logic [0:31] m, input logic [0:31] wd, input logic [0:2] inf,
                     input logic ak, input logic [0:31] rd, input logic f,
                     input logic rq, input logic we, input logic [0:3] be,
                     input logic [0:31] ewd, input logic [0:31] evm, input logic erm,
                     input logic [0:31] evw, input logic erw);
    vec_t v;
    v.ctrl = c; v.alu_ctrl = ac; v.alu_out = a; v.mult_out = m; v.wdata = wd;
    v.info = inf; v.ack = ak; v.rdata = rd; v.fp = f;
    v.e_req = rq; v.e_we = we; v.e_be = be; v.e_wdata = ewd; v.e_wval_mem = evm;
    v.e_rw_mem = erm; v.e_wval_wb = evw; v.e_rw_wb = erw;
    vecs.push_back(v);
  endtask

  task automatic set_bubble();
    ctrl = '0; alu_ctrl = '0; alu_out = '0; mult_out = '0; write_data = '0;
    dmem_info = '0; write_reg = '0; fp_reg_write = 1'b0; dmem_ack = 1'b0; dmem_rdata = '0;
  endtask

  task automatic check_wb_zero(input string tag);
    chk({tag, "_ctrl_wb"}, 32'(ctrl_wb), 32'h0);
    chk({tag, "_write_reg_wb"}, 32'(write_reg_wb), 32'h0);
    chk({tag, "_write_val_wb"}, write_val_wb, 32'h0);
    chk({tag, "_reg_write_wb"}, 32'(reg_write_wb), 32'h0);
    chk({tag, "_fp_wb"}, 32'(fp_reg_write_wb), 32'h0);
  endtask

  initial begin
    int stalls;
    rst_n = 1'b0;
    set_bubble();

    //     ctrl   actl   alu           mult          wdata         info    ak rdata         fp  rq we be       e_wdata       e_wval_mem    rm e_wval_wb     rw
    add(C_ST,  6'h20, 32'h0000_0100, 32'h0,        32'hDEAD_BEEF, 3'b010, 1, 32'h0,        0,  1, 1, 4'b1111, 32'hDEAD_BEEF, 32'h0000_0100, 0, 32'h0000_0100, 0);
    add(C_LD,  6'h20, 32'h0000_0102, 32'h0,        32'h0,         3'b001, 1, 32'h1234_ABCD, 0,  1, 0, 4'b0011, 32'h0,         32'h0000_0102, 0, 32'h0000_ABCD, 1);
    add(C_ST,  6'h20, 32'h0000_0101, 32'h0,        32'h0000_00A5, 3'b000, 1, 32'h0,        0,  1, 1, 4'b0100, 32'hA5A5_A5A5, 32'h0000_0101, 0, 32'h0000_0101, 0);
    add(C_ST,  6'h20, 32'h0000_0100, 32'h0,        32'h1234_BEEF, 3'b001, 1, 32'h0,        0,  1, 1, 4'b1100, 32'hBEEF_BEEF, 32'h0000_0100, 0, 32'h0000_0100, 0);
    add(C_LD,  6'h20, 32'h0000_0100, 32'h0,        32'h0,         3'b101, 1, 32'h8001_7FFF, 0,  1, 0, 4'b1100, 32'h0,         32'h0000_0100, 0, 32'hFFFF_8001, 1);
    add(C_LD,  6'h20, 32'h0000_0102, 32'h0,        32'h0,         3'b000, 1, 32'h1122_3344, 0,  1, 0, 4'b0010, 32'h0,         32'h0000_0102, 0, 32'h0000_0033, 1);
    add(C_LD,  6'h20, 32'h0000_0101, 32'h0,        32'h0,         3'b100, 1, 32'h11C2_3344, 0,  1, 0, 4'b0100, 32'h0,         32'h0000_0101, 0, 32'hFFFF_FFC2, 1);
    add(C_LD,  6'h20, 32'h0000_0104, 32'h0,        32'h0,         3'b110, 1, 32'h89AB_CDEF, 0,  1, 0, 4'b1111, 32'h0,         32'h0000_0104, 0, 32'h89AB_CDEF, 1);
    add(C_ALU, 6'h0e, 32'h0000_0007, 32'h0000_0042, 32'h0,        3'b010, 0, 32'h0,        1,  0, 0, 4'b1111, 32'h0,         32'h0000_0042, 1, 32'h0000_0042, 1);
    add(C_ALU, 6'h16, 32'h0000_0123, 32'hFFFF_0000, 32'h0,        3'b010, 0, 32'h0,        0,  0, 0, 4'b1111, 32'h0,         32'hFFFF_0000, 1, 32'hFFFF_0000, 1);
    add(C_ALU, 6'h20, 32'h0000_0007, 32'h0000_0042, 32'h0,        3'b010, 0, 32'h0,        1,  0, 0, 4'b1111, 32'h0,         32'h0000_0007, 1, 32'h0000_0007, 1);
    add(9'h0,  6'h00, 32'h0000_0200, 32'h0,        32'h0,         3'b010, 1, 32'h0,        0,  0, 0, 4'b1111, 32'h0,         32'h0000_0200, 0, 32'h0000_0200, 0);

    repeat (2) @(posedge clk);
    #1;
    chk("rst_req", 32'(dmem_req), 32'h0);
    chk("rst_bus_error", 32'(bus_error), 32'h0);
    chk("rst_state", 32'(fsm_state), 32'(ST_IDLE));
    check_wb_zero("rst");
    rst_n = 1'b1;

    foreach (vecs[i]) begin
      ctrl = vecs[i].ctrl; alu_ctrl = vecs[i].alu_ctrl; alu_out = vecs[i].alu_out;
      mult_out = vecs[i].mult_out; write_data = vecs[i].wdata; dmem_info = vecs[i].info;
      dmem_ack = vecs[i].ack; dmem_rdata = vecs[i].rdata; fp_reg_write = vecs[i].fp;
      write_reg = 5'(i + 1);
      @(negedge clk);
      chk($sformatf("v%0d_req", i), 32'(dmem_req), 32'(vecs[i].e_req));
      chk($sformatf("v%0d_we", i), 32'(dmem_we), 32'(vecs[i].e_we));
      chk($sformatf("v%0d_addr", i), dmem_addr, vecs[i].alu_out & 32'hFFFF_FFFC);
      chk($sformatf("v%0d_be", i), 32'(dmem_be), 32'(vecs[i].e_be));
      chk($sformatf("v%0d_wdata", i), dmem_wdata, vecs[i].e_wdata);
      chk($sformatf("v%0d_stall", i), 32'(mem_stall), 32'h0);
      chk($sformatf("v%0d_wval_mem", i), write_val_mem, vecs[i].e_wval_mem);
      chk($sformatf("v%0d_rw_mem", i), 32'(reg_write_mem), 32'(vecs[i].e_rw_mem));
      chk($sformatf("v%0d_wreg_mem", i), 32'(write_reg_mem), 32'(i + 1));
      @(posedge clk);
      #1;
      chk($sformatf("v%0d_wval_wb", i), write_val_wb, vecs[i].e_wval_wb);
      chk($sformatf("v%0d_rw_wb", i), 32'(reg_write_wb), 32'(vecs[i].e_rw_wb));
      chk($sformatf("v%0d_ctrl_wb", i), 32'(ctrl_wb), 32'(vecs[i].ctrl));
      chk($sformatf("v%0d_wreg_wb", i), 32'(write_reg_wb), 32'(i + 1));
      chk($sformatf("v%0d_fp_wb", i), 32'(fp_reg_write_wb), 32'(vecs[i].fp));
      chk($sformatf("v%0d_bus_error", i), 32'(bus_error), 32'h0);
      chk($sformatf("v%0d_state", i), 32'(fsm_state), 32'(ST_IDLE));
    end

    // Signed byte load acknowledged after three stalled cycles.
    set_bubble();
    ctrl = C_LD; alu_out = 32'h0000_0103; dmem_info = 3'b100; write_reg = 5'd7;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk($sformatf("wait%0d_stall", k), 32'(mem_stall), 32'h1);
      chk($sformatf("wait%0d_req", k), 32'(dmem_req), 32'h1);
      @(posedge clk);
      #1;
      chk($sformatf("wait%0d_ctrl_wb", k), 32'(ctrl_wb), 32'h0);
      chk($sformatf("wait%0d_rw_wb", k), 32'(reg_write_wb), 32'h0);
    end
    dmem_ack = 1'b1; dmem_rdata = 32'h0000_00F0;
    @(negedge clk);
    chk("wait_ack_stall", 32'(mem_stall), 32'h0);
    @(posedge clk);
    #1;
    chk("wait_ack_wval", write_val_wb, 32'hFFFF_FFF0);
    chk("wait_ack_rw_wb", 32'(reg_write_wb), 32'h1);
    chk("wait_ack_ctrl_wb", 32'(ctrl_wb), 32'(C_LD));
    chk("wait_ack_state", 32'(fsm_state), 32'(ST_IDLE));

    // Misaligned half store: no request, no stall, sticky error.
    set_bubble();
    ctrl = C_ST; alu_out = 32'h0000_0101; dmem_info = 3'b001; write_data = 32'h0000_1234;
    dmem_ack = 1'b1;
    @(negedge clk);
    chk("mis_error_before", 32'(bus_error), 32'h0);
    chk("mis_req", 32'(dmem_req), 32'h0);
    chk("mis_stall", 32'(mem_stall), 32'h0);
    @(posedge clk);
    #1;
    chk("mis_bus_error", 32'(bus_error), 32'h1);
    chk("mis_rw_wb", 32'(reg_write_wb), 32'h0);
    set_bubble();
    @(posedge clk);
    #1;
    chk("mis_sticky", 32'(bus_error), 32'h1);
    rst_n = 1'b0;
    #1;
    chk("mis_rst_clears", 32'(bus_error), 32'h0);
    rst_n = 1'b1;

    // Word load that is never acknowledged: 16 stalled cycles, then timeout.
    @(posedge clk);
    #1;
    ctrl = C_LD; alu_out = 32'h0000_0200; dmem_info = 3'b010; write_reg = 5'd3;
    dmem_rdata = 32'hFFFF_FFFF;
    stalls = 0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (!mem_stall) break;
      stalls++;
      @(posedge clk);
      #1;
    end
    chk("to_stall_cycles", 32'(stalls), 32'd16);
    chk("to_stall_released", 32'(mem_stall), 32'h0);
    @(posedge clk);
    #1;
    chk("to_bus_error", 32'(bus_error), 32'h1);
    chk("to_wval_zero", write_val_wb, 32'h0);
    chk("to_state", 32'(fsm_state), 32'(ST_IDLE));
    set_bubble();

    // Reset asserted while a store is waiting for its ack.
    ctrl = C_ST; alu_out = 32'h0000_0300; dmem_info = 3'b010; write_data = 32'h5555_AAAA;
    write_reg = 5'd9; fp_reg_write = 1'b1;
    repeat (2) @(posedge clk);
    #3;
    chk("mid_pre_state", 32'(fsm_state), 32'(ST_WAIT));
    chk("mid_pre_wreg_wb", 32'(write_reg_wb), 32'd9);
    chk("mid_pre_req", 32'(dmem_req), 32'h1);
    rst_n = 1'b0;
    #1;
    chk("mid_req", 32'(dmem_req), 32'h0);
    chk("mid_stall", 32'(mem_stall), 32'h0);
    chk("mid_bus_error", 32'(bus_error), 32'h0);
    chk("mid_state", 32'(fsm_state), 32'(ST_IDLE));
    check_wb_zero("mid");
    set_bubble();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    repeat (2) @(posedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1);
  end
endmodule
